// File: rtl/alu_pkg.sv
// alu_pkg: ALU_Cnt operation codes shared with ALUcontrol, plus the exec-unit FSM encoding.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SLL = 4'b0011;
    localparam logic [3:0] ALU_SRL = 4'b0100;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SRA = 4'b1000;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

    function automatic logic is_shift(input logic [3:0] code);
        return code == ALU_SLL || code == ALU_SRL || code == ALU_SRA;
    endfunction

endpackage

// File: rtl/alu_shift_iter.sv
// alu_shift_iter: one-bit-per-cycle shifter; o_done flags the cycle whose o_next is the final value.
module alu_shift_iter
    import alu_pkg::*;
#(
    parameter int WIDTH   = 64,
    parameter int SHAMT_W = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_load,
    input  logic [3:0]         i_op,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [SHAMT_W-1:0] i_shamt,
    output logic [WIDTH-1:0]   o_next,
    output logic               o_done
);

    logic [WIDTH-1:0]   r_sh;
    logic [SHAMT_W-1:0] r_cnt;
    logic               r_left;
    logic               r_arith;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sh    <= '0;
            r_cnt   <= '0;
            r_left  <= 1'b0;
            r_arith <= 1'b0;
        end else if (i_load) begin
            r_sh    <= i_a;
            r_cnt   <= i_shamt;
            r_left  <= i_op == ALU_SLL;
            r_arith <= i_op == ALU_SRA;
        end else if (r_cnt != '0) begin
            r_sh  <= o_next;
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Right shifts fill with the sign bit only for SRA.
    assign o_next = r_left ? {r_sh[WIDTH-2:0], 1'b0}
                           : {r_arith & r_sh[WIDTH-1], r_sh[WIDTH-1:1]};
    assign o_done = r_cnt == SHAMT_W'(1);

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU with valid/ready handshake; single-cycle logic ops and
// add/sub/slt, iterative shifts, registered result with zero/overflow/illegal flags.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH   = 64,
    parameter int SHAMT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ALU_Cnt,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             illegal
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_result;
    logic               r_zero;
    logic               r_ovf;
    logic               r_ill;
    logic [WIDTH-1:0]   w_res;
    logic [WIDTH-1:0]   w_sum;
    logic [WIDTH-1:0]   w_diff;
    logic [WIDTH-1:0]   w_sh_next;
    logic [SHAMT_W-1:0] w_shamt;
    logic               w_ovf;
    logic               w_ill;
    logic               w_accept;
    logic               w_go_shift;
    logic               w_sh_done;

    assign w_shamt    = b[SHAMT_W-1:0];
    assign w_sum      = a + b;
    assign w_diff     = a - b;
    assign in_ready   = r_state == IDLE || (r_state == HOLD && out_ready);
    assign w_accept   = in_valid && in_ready;
    assign w_go_shift = w_accept && is_shift(ALU_Cnt) && w_shamt != '0;
    assign out_valid  = r_state == HOLD;
    assign result     = r_result;
    assign zero       = r_zero;
    assign overflow   = r_ovf;
    assign illegal    = r_ill;

    alu_shift_iter #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_shift (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_accept && is_shift(ALU_Cnt)),
        .i_op    (ALU_Cnt),
        .i_a     (a),
        .i_shamt (w_shamt),
        .o_next  (w_sh_next),
        .o_done  (w_sh_done)
    );

    // Shift codes land here only with a zero shift amount, where the result is a itself.
    always_comb begin
        w_res = '0;
        w_ovf = 1'b0;
        w_ill = 1'b0;
        case (ALU_Cnt)
            ALU_AND: w_res = a & b;
            ALU_OR:  w_res = a | b;
            ALU_NOR: w_res = ~(a | b);
            ALU_ADD: begin
                w_res = w_sum;
                w_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SUB: begin
                w_res = w_diff;
                w_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SLT: w_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_SLL, ALU_SRL, ALU_SRA: w_res = a;
            default: w_ill = 1'b1;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_accept)
            w_state_nxt = w_go_shift ? SHIFT : HOLD;
        else if (r_state == SHIFT)
            w_state_nxt = w_sh_done ? HOLD : SHIFT;
        else if (r_state == HOLD)
            w_state_nxt = out_ready ? IDLE : HOLD;
        else
            w_state_nxt = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_ovf    <= 1'b0;
            r_ill    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept && !w_go_shift) begin
                r_result <= w_res;
                r_zero   <= w_res == '0;
                r_ovf    <= w_ovf;
                r_ill    <= w_ill;
            end else if (r_state == SHIFT && w_sh_done) begin
                r_result <= w_sh_next;
                r_zero   <= w_sh_next == '0;
                r_ovf    <= 1'b0;
                r_ill    <= 1'b0;
            end
        end
    end

endmodule
